// File: rtl/spi_rx_framer.sv
// SPI receive framer: SOF, length, payload into a read buffer, optional XOR checksum.
// Optional checksum stage is enabled by defining SPI_RX_FRAMER_CHK_EN.
module spi_rx_framer #(
  parameter int               WIDTH   = 8,
  parameter int               MAX_LEN = 16,
  parameter logic [WIDTH-1:0] SOF     = 8'hA5,
  localparam int              AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [7:0]       frame_len,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [7:0]       frame_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHK} state_t;

  state_t           state, state_nxt;
  logic [7:0]       len;
  logic [7:0]       idx;
  logic [WIDTH-1:0] buf_mem [MAX_LEN];
  logic             ok_nxt, err_nxt, len_ld, wr_en;
  logic [1:0]       code_nxt;
  logic             len_ok;
`ifdef SPI_RX_FRAMER_CHK_EN
  logic [WIDTH-1:0] chk;
`endif

  assign len_ok = (in_data != '0) && (in_data <= WIDTH'(MAX_LEN));

  always_comb begin
    state_nxt = state;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    len_ld    = 1'b0;
    wr_en     = 1'b0;
    if (cs_n) begin
      // Deselect mid-frame aborts; an idle deselect is harmless.
      if (state != IDLE) begin
        err_nxt   = 1'b1;
        code_nxt  = 2'd3;
        state_nxt = IDLE;
      end
    end else if (in_valid) begin
      case (state)
        IDLE: if (in_data == SOF) state_nxt = LEN;
        LEN: begin
          if (len_ok) begin
            len_ld    = 1'b1;
            state_nxt = PAYLOAD;
          end else begin
            err_nxt   = 1'b1;
            code_nxt  = 2'd1;
            state_nxt = IDLE;
          end
        end
        PAYLOAD: begin
          wr_en = 1'b1;
          if (idx == len - 8'd1) begin
`ifdef SPI_RX_FRAMER_CHK_EN
            state_nxt = CHK;
`else
            ok_nxt    = 1'b1;
            state_nxt = IDLE;
`endif
          end
        end
`ifdef SPI_RX_FRAMER_CHK_EN
        CHK: begin
          state_nxt = IDLE;
          if (in_data == chk) begin
            ok_nxt = 1'b1;
          end else begin
            err_nxt  = 1'b1;
            code_nxt = 2'd2;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      len         <= '0;
      idx         <= '0;
      frame_len   <= '0;
      frame_cnt   <= '0;
      err_code    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef SPI_RX_FRAMER_CHK_EN
      chk         <= '0;
`endif
    end else begin
      frame_valid <= ok_nxt;
      frame_err   <= err_nxt;
      err_code    <= code_nxt;
      if (len_ld) begin
        len <= 8'(in_data);
        idx <= '0;
`ifdef SPI_RX_FRAMER_CHK_EN
        chk <= in_data;
`endif
      end
      if (wr_en) begin
        idx <= idx + 8'd1;
`ifdef SPI_RX_FRAMER_CHK_EN
        chk <= chk ^ in_data;
`endif
      end
      if (ok_nxt) begin
        frame_len <= len;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Payload storage is left unreset so it can map onto plain RAM.
  always_ff @(posedge sclk) begin
    if (wr_en) buf_mem[idx[AW-1:0]] <= in_data;
  end

  assign rd_data = ({1'b0, rd_addr} < (AW+1)'(MAX_LEN)) ? buf_mem[rd_addr] : '0;
  assign busy    = (state != IDLE);

endmodule

// File: doc/spi_rx_framer.md
SPI_RX_FRAMER -- requirements
Module: spi_rx_framer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the byte width of received data.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, giving the maximum payload bytes per frame (range 1..255).
REQ-003 The block SHALL have parameter SOF, default 8'hA5, giving the start-of-frame byte value.
REQ-004 The block SHALL have port sclk, input, 1 bit: SPI clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port cs_n, input, 1 bit: chip select, active-low, sampled on sclk.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: received byte from the SPI receiver.
REQ-008 The block SHALL have port in_valid, input, 1 bit: one-sclk-cycle strobe qualifying in_data.
REQ-009 The block SHALL have port rd_addr, input, clog2(MAX_LEN) bits: payload buffer read index.
REQ-010 The block SHALL have port rd_data, output, WIDTH bits: payload byte at rd_addr, combinational read.
REQ-011 The block SHALL have port frame_len, output, 8 bits: payload length of the last good frame.
REQ-012 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse on good frame completion.
REQ-013 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on frame error.
REQ-014 The block SHALL have port err_code, output, 2 bits: 1 = bad length, 2 = bad checksum, 3 = abort; it holds until the next error.
REQ-015 The block SHALL have port frame_cnt, output, 8 bits: count of good frames, wrapping 255->0.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, LEN, PAYLOAD, CHK; each state advances only on a cycle with in_valid=1 and cs_n=0.
REQ-018 IDLE: on in_data==SOF, go to LEN; other bytes are discarded silently, with no error.
REQ-019 LEN: on in_data in 1..MAX_LEN, latch len, clear idx to 0, seed chk=in_data and go to PAYLOAD; on 0 or >MAX_LEN, frame_err with err_code=1, go to IDLE.
REQ-020 PAYLOAD: write in_data to buf[idx], set chk^=in_data, idx+1; after the byte with idx==len-1, go to CHK.
REQ-021 CHK: if in_data==chk, pulse frame_valid, update frame_len=len, increment frame_cnt; otherwise frame_err with err_code=2; go to IDLE in both cases.
REQ-022 frame_valid and frame_err SHALL assert in the cycle after the completing in_valid and SHALL never assert together.
REQ-023 cs_n=1 sampled in any non-IDLE state SHALL pulse frame_err with err_code=3 and force IDLE; cs_n=1 in IDLE has no effect.
REQ-024 in_valid with cs_n=1 SHALL be ignored; abort takes priority.
REQ-025 The buffer SHALL be overwritten by the next frame's payload; the payload is valid for reading from frame_valid until the next SOF+LEN is accepted.
REQ-026 A SOF value arriving in LEN, PAYLOAD or CHK SHALL be treated as ordinary data, with no resynchronisation.
REQ-027 rd_addr >= MAX_LEN SHALL return 0 on rd_data.

Reset
REQ-028 rst=1 SHALL immediately force IDLE and clear idx, len, chk, frame_len, frame_cnt, err_code, frame_valid, frame_err and busy to 0.
REQ-029 Buffer contents need not be reset; rd_data is undefined until the first frame completes.
REQ-030 Reset during a frame SHALL discard the frame with no error pulse.

Configuration
REQ-031 With macro SPI_RX_FRAMER_CHK_EN defined, the CHK state and checksum compare of REQ-021 SHALL be present.
REQ-032 Without SPI_RX_FRAMER_CHK_EN, PAYLOAD SHALL complete the frame directly on the last payload byte (frame_valid with the same latency), err_code=2 SHALL never occur, and the chk logic SHALL be removed.

Verification
REQ-033 The bench SHALL cover the good frame: with CHK_EN, send A5,03,11,22,33,03 -> frame_valid pulse, frame_len=3, rd_data[0..2]=11,22,33, frame_cnt=1.
REQ-034 The bench SHALL cover the bad checksum: send A5,02,10,20,00 -> frame_err pulse, err_code=2, frame_cnt unchanged, busy=0.
REQ-035 The bench SHALL cover the bad length: send A5,00, then A5,11 with MAX_LEN=16 -> two frame_err pulses, err_code=1 each, and IDLE after each.
REQ-036 The bench SHALL cover the abort: send A5,04,01,02, then drive cs_n=1 for one sclk -> frame_err, err_code=3, IDLE; a following good frame is accepted.
REQ-037 The bench SHALL cover noise plus wrap: send 00,FF,5A, then 256 good frames -> no errors, frame_cnt=0 at the end.
REQ-038 The bench SHALL cover reset mid-frame: assert rst during PAYLOAD -> all outputs 0 immediately, no frame_err pulse.
